// File: rtl/pipe_trace_capture.sv
// pipe_trace_capture: observes the pipelined MIPS top. Each time the PC changes
// (while capture is enabled) it stores a {PC, WB result, HI, LO} record in a FIFO,
// then streams the records out one 32-bit word at a time over a valid/ready port.
module pipe_trace_capture #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     CaptureEn,
  input  logic                     Clear,
  input  logic [31:0]              PCResult,
  input  logic [31:0]              MEMWB_ALUResult,
  input  logic [31:0]              ALUhi,
  input  logic [31:0]              ALUlo,
  output logic [31:0]              TraceData,
  output logic                     TraceValid,
  input  logic                     TraceReady,
  output logic                     TraceLast,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow,
  output logic [DROP_W-1:0]        DropCount
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] W_PC  = 3'd1;
  localparam logic [2:0] W_RES = 3'd2;
  localparam logic [2:0] W_HI  = 3'd3;
  localparam logic [2:0] W_LO  = 3'd4;

  logic [2:0]    state;
  logic [31:0]   prev_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;

  // Record storage; data only, never reset.
  logic [31:0] mem_pc  [DEPTH];
  logic [31:0] mem_res [DEPTH];
  logic [31:0] mem_hi  [DEPTH];
  logic [31:0] mem_lo  [DEPTH];

  logic trig;
  logic full;
  logic accept;
  logic pop;
  logic push;
  logic drop;

  // Saturating increment for the dropped-record counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  // Trigger, FIFO handshake and occupancy arithmetic.
  always_comb begin
    trig   = CaptureEn && (PCResult != prev_pc);
    full   = (count == (AW+1)'(DEPTH));
    accept = TraceValid && TraceReady;
    pop    = accept && (state == W_LO);
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    push   = trig && (!full || pop);
    drop   = trig && full && !pop;
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Record write; Clear suppresses the push.
  always_ff @(posedge Clk) begin
    if (push && !Clear) begin
      mem_pc[wr_ptr]  <= PCResult;
      mem_res[wr_ptr] <= MEMWB_ALUResult;
      mem_hi[wr_ptr]  <= ALUhi;
      mem_lo[wr_ptr]  <= ALUlo;
    end
  end

  // Control state: previous PC, pointers, occupancy, status and output FSM.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      prev_pc   <= 32'hFFFF_FFFF;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      Overflow  <= 1'b0;
      DropCount <= '0;
    end else begin
      prev_pc <= PCResult;
      if (Clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        state     <= IDLE;
        Overflow  <= 1'b0;
        DropCount <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count_next;
        if (drop) begin
          Overflow  <= 1'b1;
          DropCount <= sat_inc(DropCount);
        end
        case (state)
          IDLE:    if (count != '0) state <= W_PC;
          W_PC:    if (accept) state <= W_RES;
          W_RES:   if (accept) state <= W_HI;
          W_HI:    if (accept) state <= W_LO;
          // Chain straight into the next record when one is waiting.
          W_LO:    if (accept) state <= (count_next != '0) ? W_PC : IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Output word selection from the head record; holds while the sink stalls.
  always_comb begin
    TraceValid = (state != IDLE);
    TraceLast  = (state == W_LO);
    TraceData  = 32'h0;
    case (state)
      W_PC:    TraceData = mem_pc[rd_ptr];
      W_RES:   TraceData = mem_res[rd_ptr];
      W_HI:    TraceData = mem_hi[rd_ptr];
      W_LO:    TraceData = mem_lo[rd_ptr];
      default: TraceData = 32'h0;
    endcase
  end

  assign Count = count;

endmodule

// File: tb/tb_pipe_trace_capture.sv
// Bench for pipe_trace_capture: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a queue-based model of the trace stream.
module tb_pipe_trace_capture;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 3;

  logic        clk;
  logic        rst_n;
  logic        cap;
  logic        clr;
  logic [31:0] pc;
  logic [31:0] res;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        rdy;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic [3:0]  cnt;
  logic        ovf;
  logic [DROP_W-1:0] drops;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_trace_capture #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .Clk(clk), .Reset(rst_n), .CaptureEn(cap), .Clear(clr),
    .PCResult(pc), .MEMWB_ALUResult(res), .ALUhi(hi), .ALUlo(lo),
    .TraceData(tdata), .TraceValid(tvalid), .TraceReady(rdy), .TraceLast(tlast),
    .Count(cnt), .Overflow(ovf), .DropCount(drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of pending records and the index of the word on the port.
  logic [3:0][31:0] m_q[$];
  int          m_phase;   // -1: nothing offered, 0..3: word PC/RES/HI/LO
  logic [31:0] m_prev;
  logic        m_ovf;
  int          m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = -1;
    m_prev  = 32'hFFFF_FFFF;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  task automatic model_update();
    int  old_size;
    bit  trig;
    bit  popped;
    old_size = m_q.size();
    popped   = 0;
    if (clr) begin
      m_q.delete();
      m_phase = -1;
      m_ovf   = 1'b0;
      m_drop  = 0;
      m_prev  = pc;
      return;
    end
    trig   = cap && (pc != m_prev);
    m_prev = pc;
    if (m_phase >= 0 && rdy) begin
      if (m_phase == 3) begin
        m_q.delete(0);
        popped = 1;
      end else begin
        m_phase++;
      end
    end
    if (trig) begin
      if (m_q.size() < DEPTH) m_q.push_back({pc, res, hi, lo});
      else begin
        m_ovf = 1'b1;
        if (m_drop < (1 << DROP_W) - 1) m_drop++;
      end
    end
    if (popped) m_phase = (m_q.size() != 0) ? 0 : -1;
    else if (m_phase == -1 && old_size != 0) m_phase = 0;
  endtask

  task automatic compare_all();
    logic [3:0][31:0] head;
    chk("valid", 64'(tvalid), 64'(m_phase >= 0));
    chk("last",  64'(tlast),  64'(m_phase == 3));
    if (m_phase >= 0) begin
      head = m_q[0];
      chk("data", 64'(tdata), 64'(head[3 - m_phase]));
    end
    chk("count", 64'(cnt),   64'(m_q.size()));
    chk("ovf",   64'(ovf),   64'(m_ovf));
    chk("drops", 64'(drops), 64'(m_drop));
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc  = v;
    res = $urandom;
    hi  = $urandom;
    lo  = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_data"},  64'(tdata),  64'h0);
    chk({tag, "_valid"}, 64'(tvalid), 64'h0);
    chk({tag, "_last"},  64'(tlast),  64'h0);
    chk({tag, "_count"}, 64'(cnt),    64'h0);
    chk({tag, "_ovf"},   64'(ovf),    64'h0);
    chk({tag, "_drops"}, 64'(drops),  64'h0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; cap = 1'b0; clr = 1'b0; rdy = 1'b0;
    pc = '0; res = '0; hi = '0; lo = '0;
    model_reset();
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // PC 0,4,8 with sink always ready: twelve words, three records.
    cap = 1'b1; rdy = 1'b1;
    set_pc(32'h0); tick();
    set_pc(32'h4); tick();
    set_pc(32'h8); tick();
    for (int i = 0; i < 15; i++) tick();
    chk("t1_count_drained", 64'(cnt), 64'h0);

    // PC held for five cycles: a single record.
    set_pc(32'h10);
    for (int i = 0; i < 5; i++) tick();
    for (int i = 0; i < 6; i++) tick();

    // Capture disabled while PC moves.
    cap = 1'b0;
    for (int i = 0; i < 6; i++) begin set_pc(32'h200 + 32'(i) * 4); tick(); end
    chk("noen_count", 64'(cnt), 64'h0);
    chk("noen_valid", 64'(tvalid), 64'h0);
    cap = 1'b1;

    // Sink stalled, ten distinct PCs into an 8-deep FIFO.
    rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin set_pc(32'h100 + 32'(i) * 4); tick(); end
    for (int i = 0; i < 3; i++) tick();
    chk("ovfl_count", 64'(cnt), 64'd8);
    chk("ovfl_flag",  64'(ovf), 64'd1);
    chk("ovfl_drops", 64'(drops), 64'd2);
    chk("ovfl_head",  64'(tdata), 64'h100);
    rdy = 1'b1;
    for (int i = 0; i < 34; i++) tick();
    chk("drain_count", 64'(cnt), 64'h0);

    // Refill to full, then accept W_LO on the same edge as a new trigger.
    rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin set_pc(32'h300 + 32'(i) * 4); tick(); end
    rdy = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (m_phase == 3) found = 1;
    end
    chk("reach_wlo", 64'(found), 64'd1);
    set_pc(32'h400); tick();
    chk("fullpop_count", 64'(cnt), 64'd8);
    chk("fullpop_drops", 64'(drops), 64'd2);

    // Clear while the HI word is on the port.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_phase == 2) found = 1;
      else tick();
    end
    chk("reach_whi", 64'(found), 64'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("clr_valid", 64'(tvalid), 64'h0);
    chk("clr_count", 64'(cnt),    64'h0);
    chk("clr_ovf",   64'(ovf),    64'h0);
    chk("clr_drops", 64'(drops),  64'h0);

    // Reset asserted while the RES word is on the port.
    set_pc(32'h500); tick();
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_phase == 1) found = 1;
      else tick();
    end
    chk("reach_wres", 64'(found), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    set_pc(32'h600); tick();
    for (int i = 0; i < 8; i++) tick();

    // Randomized traffic with varying sink readiness.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 1500; i++) begin
        cap = ($urandom_range(0, 9) != 0);
        clr = ($urandom_range(0, 149) == 0);
        rdy = ($urandom_range(0, 3) < r + 1);
        if ($urandom_range(0, 2) != 0) set_pc(32'($urandom_range(0, 7)) << 2);
        tick();
      end
    end
    clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
